// File: rtl/ps2_mouse_rx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 mouse receiver.
//   frame_state_t   : 11-bit frame decoder states
//   PKT_BYTES       : bytes per mouse packet (status, X, Y)
//   STATUS_SYNC_BIT : bit of the status byte that is always 1
//   DATA_BITS       : data bits per frame
//   odd_parity_ok() : true when data byte plus parity bit has odd weight
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam int PKT_BYTES       = 3;
    localparam int STATUS_SYNC_BIT = 3;
    localparam int DATA_BITS       = 8;

    function automatic logic odd_parity_ok(input logic [7:0] data_byte,
                                           input logic       parity_bit);
        return ^{data_byte, parity_bit};
    endfunction

endpackage

// File: rtl/ps2_mouse_rx_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Two-flop synchroniser followed by a debounce filter for one raw PS/2 line.
// The filtered level only moves after FILTER_LEN consecutive synchronised
// samples disagree with it, so shorter glitches never reach the decoder.
// Ports:
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_line         : raw asynchronous line (idles high)
//   o_level        : filtered level
//   o_fall         : one-cycle strobe, registered together with the 1->0
//                    transition of o_level
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            // r_cnt counts consecutive samples that differ from the current
            // level; any agreeing sample restarts the count.
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_fall  <= r_level;  // old level 1 means this is a fall
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_mouse_rx.sv
// ---------------------------------------------------------------------------
// ps2_mouse_rx
// Receives PS/2 mouse traffic and presents the last good 3-byte packet.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   ps2_clk      : raw PS/2 clock line (asynchronous)
//   ps2_data     : raw PS/2 data line (asynchronous)
//   ps2_mouse    : {new_pkt, Y, X, status}; [23:0] holds the last packet
//   frame_err    : one-cycle pulse on parity or stop-bit error
//   sync_err     : one-cycle pulse when a leading byte lacks the sync bit
//   timeout_err  : one-cycle pulse when a partial frame/packet is aborted
// Handshake: ps2_mouse[24] is a valid strobe with no ready; the consumer
// must take [23:0] on the cycle [24] is high (the data also stays stable
// until the next strobe). All four pulses are mutually exclusive.
// ---------------------------------------------------------------------------
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 43000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [24:0] ps2_mouse,
    output logic        frame_err,
    output logic        sync_err,
    output logic        timeout_err
);

    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [1:0]      IDX_LAST  = 2'(PKT_BYTES - 1);

    logic w_clk_level;
    logic w_clk_fall;
    logic w_data;
    logic w_data_fall;
    logic w_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk   (clk),
        .i_reset (reset),
        .i_line  (ps2_clk),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .i_clk   (clk),
        .i_reset (reset),
        .i_line  (ps2_data),
        .o_level (w_data),
        .o_fall  (w_data_fall)
    );

    // Only the clock's fall and the data's level matter to the decoder.
    assign w_unused = ^{w_clk_level, w_data_fall};

    frame_state_t  r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [1:0]    r_idx;
    logic [7:0]    r_status;
    logic [7:0]    r_x;
    logic [23:0]   r_pkt;
    logic          r_new;
    logic          r_frame_err;
    logic          r_sync_err;
    logic          r_timeout_err;
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_par_ok      <= 1'b0;
            r_idx         <= '0;
            r_status      <= '0;
            r_x           <= '0;
            r_pkt         <= '0;
            r_new         <= 1'b0;
            r_frame_err   <= 1'b0;
            r_sync_err    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_new         <= 1'b0;
            r_frame_err   <= 1'b0;
            r_sync_err    <= 1'b0;
            r_timeout_err <= 1'b0;

            if (w_clk_fall) begin
                // A fall always wins over a simultaneous expiry.
                r_to_cnt <= '0;
                case (r_state)
                    IDLE: begin
                        // A high start bit is treated as line noise.
                        if (!w_data) begin
                            r_state   <= SHIFT;
                            r_bit_cnt <= '0;
                        end
                    end
                    SHIFT: begin
                        r_shift <= {w_data, r_shift[7:1]};  // LSB first
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        r_par_ok <= odd_parity_ok(r_shift, w_data);
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (w_data && r_par_ok) begin
                            if (r_idx == 2'd0) begin
                                // The status byte carries a constant 1 that
                                // lets us find packet boundaries again.
                                if (r_shift[STATUS_SYNC_BIT]) begin
                                    r_status <= r_shift;
                                    r_idx    <= 2'd1;
                                end else begin
                                    r_sync_err <= 1'b1;
                                end
                            end else if (r_idx != IDX_LAST) begin
                                r_x   <= r_shift;
                                r_idx <= r_idx + 2'd1;
                            end else begin
                                r_pkt <= {r_shift, r_x, r_status};
                                r_new <= 1'b1;
                                r_idx <= 2'd0;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_idx       <= 2'd0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE || r_idx != 2'd0) begin
                // Expiry returns everything to idle, so the counter stops
                // and cannot wrap.
                if (r_to_cnt == TO_LAST) begin
                    r_state       <= IDLE;
                    r_idx         <= 2'd0;
                    r_timeout_err <= 1'b1;
                    r_to_cnt      <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign ps2_mouse   = {r_new, r_pkt};
    assign frame_err   = r_frame_err;
    assign sync_err    = r_sync_err;
    assign timeout_err = r_timeout_err;

endmodule
